// File: rtl/compressed_line_packer_if.sv
// compressed_line_packer_if: input beat stream and packed output line handshake bundle.
interface compressed_line_packer_if #(
  parameter int WORD_WIDTH   = 8,
  parameter int R_DIST_WIDTH = 2,
  parameter int PACK_SIZE    = 4,
  parameter int CNT_WIDTH    = 3
);
  logic                               in_valid;
  logic                               in_ready;
  logic [WORD_WIDTH-1:0]              in_word;
  logic [R_DIST_WIDTH-1:0]            in_idx;
  logic                               in_keep;
  logic                               in_last;
  logic                               out_valid;
  logic                               out_ready;
  logic [WORD_WIDTH*PACK_SIZE-1:0]    out_data;
  logic [R_DIST_WIDTH*PACK_SIZE-1:0]  out_idx;
  logic [CNT_WIDTH-1:0]               out_cnt;
  logic                               out_row_end;
  modport master (
    output in_valid, in_word, in_idx, in_keep, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_cnt, out_row_end
  );
  modport slave (
    input  in_valid, in_word, in_idx, in_keep, in_last, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_cnt, out_row_end
  );
endinterface

// File: rtl/compressed_line_packer.sv
// compressed_line_packer: packs tagged nonzero words into dense lines, closing on full or row end.
module compressed_line_packer #(
  parameter int WORD_WIDTH   = 8,
  parameter int MAX_R_SIZE   = 4,
  parameter int R_DIST_WIDTH = 2,
  parameter int PACK_SIZE    = 4,
  parameter int CNT_WIDTH    = 3,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  compressed_line_packer_if.slave      bus,
  output logic [STAT_WIDTH-1:0]        lines_emitted
);
  if ((1 << R_DIST_WIDTH) < MAX_R_SIZE || PACK_SIZE < 2 || (1 << CNT_WIDTH) <= PACK_SIZE) begin : g_bad_params
    $error("compressed_line_packer: inconsistent parameters");
  end
  localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(PACK_SIZE - 1);
  logic [PACK_SIZE-1:0][WORD_WIDTH-1:0]   acc_data, line_data;
  logic [PACK_SIZE-1:0][R_DIST_WIDTH-1:0] acc_idx, line_idx;
  logic [CNT_WIDTH-1:0]                   acc_cnt, n_cnt;
  logic                                   accept, close;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  assign close  = accept && (bus.in_last || (bus.in_keep && acc_cnt == LAST_SLOT));
  assign n_cnt  = acc_cnt + CNT_WIDTH'(bus.in_keep);
  // Candidate accumulator contents with the incoming word merged; slots past the fill are forced to zero.
  always_comb begin
    for (int k = 0; k < PACK_SIZE; k++) begin
      line_data[k] = (bus.in_keep && acc_cnt == CNT_WIDTH'(k)) ? bus.in_word
                   : (CNT_WIDTH'(k) < acc_cnt) ? acc_data[k] : '0;
      line_idx[k]  = (bus.in_keep && acc_cnt == CNT_WIDTH'(k)) ? bus.in_idx
                   : (CNT_WIDTH'(k) < acc_cnt) ? acc_idx[k] : '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_data        <= '0;
      acc_idx         <= '0;
      acc_cnt         <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_idx     <= '0;
      bus.out_cnt     <= '0;
      bus.out_row_end <= 1'b0;
      lines_emitted   <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready) lines_emitted <= lines_emitted + 1'b1;
      if (close) begin
        bus.out_data    <= line_data;
        bus.out_idx     <= line_idx;
        bus.out_cnt     <= n_cnt;
        bus.out_row_end <= bus.in_last;
        bus.out_valid   <= 1'b1;
        acc_data        <= '0;
        acc_idx         <= '0;
        acc_cnt         <= '0;
      end else begin
        if (bus.out_ready) bus.out_valid <= 1'b0;
        if (accept && bus.in_keep) begin
          acc_data <= line_data;
          acc_idx  <= line_idx;
          acc_cnt  <= n_cnt;
        end
      end
    end
  end
endmodule

// File: tb/tb_compressed_line_packer.sv
// tb_compressed_line_packer: directed checks of packing, flush, back-pressure and reset.
module tb_compressed_line_packer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] lines_emitted;
  int          tests = 0;
  int          fails = 0;
  compressed_line_packer_if #(.WORD_WIDTH(8), .R_DIST_WIDTH(2), .PACK_SIZE(4), .CNT_WIDTH(3)) bus ();
  compressed_line_packer #(
    .WORD_WIDTH(8), .MAX_R_SIZE(4), .R_DIST_WIDTH(2), .PACK_SIZE(4), .CNT_WIDTH(3), .STAT_WIDTH(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .lines_emitted(lines_emitted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] w, input logic [1:0] idx, input logic keep, input logic last);
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    bus.in_idx   = idx;
    bus.in_keep  = keep;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_line(input string tag, input logic [31:0] d, input logic [7:0] i, input logic [2:0] c, input logic re);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1'b1));
    chk({tag, "_data"}, 64'(bus.out_data), 64'(d));
    chk({tag, "_idx"}, 64'(bus.out_idx), 64'(i));
    chk({tag, "_cnt"}, 64'(bus.out_cnt), 64'(c));
    chk({tag, "_row_end"}, 64'(bus.out_row_end), 64'(re));
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_word = '0;
    bus.in_idx = '0;
    bus.in_keep = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.out_valid), 0);
    chk("rst_data", 64'(bus.out_data), 0);
    chk("rst_cnt", 64'(bus.out_cnt), 0);
    chk("rst_lines", 64'(lines_emitted), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    @(negedge clk) reset_n = 1'b1;
    idle();
    send(8'h11, 2'd0, 1, 0);
    send(8'h22, 2'd1, 1, 0);
    send(8'h33, 2'd2, 1, 0);
    send(8'h44, 2'd3, 1, 0);
    chk_line("full", 32'h44332211, 8'hE4, 3'd4, 1'b0);
    chk("full_lines_pre", 64'(lines_emitted), 0);
    idle();
    chk("full_done_valid", 64'(bus.out_valid), 0);
    chk("full_lines", 64'(lines_emitted), 1);
    send(8'h05, 2'd1, 1, 0);
    send(8'h07, 2'd3, 1, 1);
    chk_line("partial", 32'h00000705, 8'h0D, 3'd2, 1'b1);
    idle();
    chk("partial_lines", 64'(lines_emitted), 2);
    send(8'hAA, 2'd2, 0, 1);
    chk_line("empty", 32'h0, 8'h0, 3'd0, 1'b1);
    idle();
    chk("empty_lines", 64'(lines_emitted), 3);
    bus.out_ready = 1'b0;
    send(8'h10, 2'd0, 1, 0);
    send(8'h20, 2'd1, 1, 1);
    chk_line("bp_line", 32'h00002010, 8'h04, 3'd2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_word = 8'h50 + 8'(i);
      bus.in_idx = 2'(i);
      bus.in_keep = 1'b1;
      bus.in_last = 1'b0;
      #1;
      chk("bp_in_ready", 64'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      chk("bp_stable_data", 64'(bus.out_data), 64'h2010);
      chk("bp_stable_valid", 64'(bus.out_valid), 1);
    end
    chk("bp_lines", 64'(lines_emitted), 3);
    bus.in_word = 8'h5A;
    bus.in_idx = 2'd2;
    bus.in_last = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk_line("bp_after", 32'h0000005A, 8'h02, 3'd1, 1'b1);
    chk("bp_after_lines", 64'(lines_emitted), 4);
    send(8'h01, 2'd0, 1, 0);
    chk("sim_drain_valid", 64'(bus.out_valid), 0);
    send(8'h02, 2'd1, 1, 0);
    send(8'h03, 2'd2, 1, 0);
    send(8'h04, 2'd3, 1, 0);
    chk_line("sim_first", 32'h04030201, 8'hE4, 3'd4, 1'b0);
    chk("sim_lines_pre", 64'(lines_emitted), 5);
    send(8'h09, 2'd0, 1, 1);
    chk_line("sim_second", 32'h00000009, 8'h00, 3'd1, 1'b1);
    chk("sim_lines", 64'(lines_emitted), 6);
    send(8'hA1, 2'd0, 1, 0);
    send(8'hA2, 2'd1, 1, 0);
    send(8'hA3, 2'd2, 1, 0);
    send(8'hA4, 2'd3, 1, 1);
    chk_line("full_row_end", 32'hA4A3A2A1, 8'hE4, 3'd4, 1'b1);
    idle();
    chk("no_extra_line", 64'(bus.out_valid), 0);
    chk("fre_lines", 64'(lines_emitted), 8);
    send(8'hB1, 2'd0, 1, 0);
    send(8'hB2, 2'd1, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 0);
    chk("mid_rst_data", 64'(bus.out_data), 0);
    chk("mid_rst_idx", 64'(bus.out_idx), 0);
    chk("mid_rst_cnt", 64'(bus.out_cnt), 0);
    chk("mid_rst_row_end", 64'(bus.out_row_end), 0);
    chk("mid_rst_lines", 64'(lines_emitted), 0);
    @(negedge clk) reset_n = 1'b1;
    idle();
    send(8'hC1, 2'd0, 1, 0);
    send(8'hC2, 2'd1, 1, 0);
    send(8'hC3, 2'd2, 1, 0);
    send(8'hC4, 2'd3, 1, 0);
    chk_line("post_rst", 32'hC4C3C2C1, 8'hE4, 3'd4, 1'b0);
    idle();
    chk("post_rst_lines", 64'(lines_emitted), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
